// File: rtl/core_pkg.sv
// Shared MIPS core definitions: opcodes, ALUOp encodings and the decoder control bundle.
// ID_EX_PERF_CNT_EN additionally enables the saturating counter helper.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam int CTRL_W = 11;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       bne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(11'b0);

  // An instruction reads rt as a source unless it takes the immediate; stores always read rt.
  function automatic logic uses_rt_f(input ctrl_t c);
    return ~c.alu_src | c.mem_write;
  endfunction

`ifdef ID_EX_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction
`endif

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID instruction.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              uses_rt,
  output logic              hazard
);

  logic rt_nonzero_s;
  logic rs_match_s;
  logic rt_match_s;

  // $zero is never a real producer, so it can never cause a stall.
  assign rt_nonzero_s = (ex_rt != {REG_AW{1'b0}});
  assign rs_match_s   = (ex_rt == id_rs);
  assign rt_match_s   = uses_rt & (ex_rt == id_rt);
  assign hazard       = ex_mem_read & ex_valid & rt_nonzero_s & (rs_match_s | rt_match_s);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall and branch/jump flush bubbles.
// Optional ID_EX_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module id_ex_pipe
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_jump,
  input  logic              id_Branch,
  input  logic              id_Bne,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic              id_RegDst,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush_i,
  output logic              ex_jump,
  output logic              ex_Branch,
  output logic              ex_Bne,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic              ex_RegDst,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic              ex_valid,
  output logic              stall_o,
  output logic              pc_write_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              ifid_write_o
);

  ctrl_t id_ctrl_s;
  ctrl_t ctrl_nxt_s;
  ctrl_t ctrl_r;
  logic  valid_nxt_s;
  logic  valid_r;
  logic  hazard_s;
  logic  stall_s;

  assign id_ctrl_s = '{jump:       id_jump,
                       branch:     id_Branch,
                       bne:        id_Bne,
                       mem_read:   id_MemRead,
                       mem_to_reg: id_MemtoReg,
                       mem_write:  id_MemWrite,
                       alu_src:    id_ALUSrc,
                       reg_write:  id_RegWrite,
                       reg_dst:    id_RegDst,
                       alu_op:     id_ALUOp};

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_mem_read (ctrl_r.mem_read),
    .ex_valid    (valid_r),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .uses_rt     (uses_rt_f(id_ctrl_s)),
    .hazard      (hazard_s)
  );

  // A flush already kills the dependent instruction, so it suppresses the stall.
  assign stall_s      = hazard_s & ~flush_i;
  assign stall_o      = stall_s;
  assign pc_write_o   = ~stall_s;
  assign ifid_write_o = ~stall_s;

  // Select a bubble on flush or stall, otherwise pass the decoded control through.
  always_comb begin
    ctrl_nxt_s  = CTRL_BUBBLE;
    valid_nxt_s = 1'b0;
    if (flush_i || stall_s) begin
      ctrl_nxt_s  = CTRL_BUBBLE;
      valid_nxt_s = 1'b0;
    end else begin
      ctrl_nxt_s  = id_ctrl_s;
      valid_nxt_s = 1'b1;
    end
  end

  // Pipeline register: control bundle, valid flag and data fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r     <= CTRL_BUBBLE;
      valid_r    <= 1'b0;
      ex_rs_data <= {DATA_W{1'b0}};
      ex_rt_data <= {DATA_W{1'b0}};
      ex_imm     <= {DATA_W{1'b0}};
      ex_pc4     <= {DATA_W{1'b0}};
      ex_rs      <= {REG_AW{1'b0}};
      ex_rt      <= {REG_AW{1'b0}};
      ex_rd      <= {REG_AW{1'b0}};
      ex_funct   <= 6'd0;
    end else begin
      ctrl_r     <= ctrl_nxt_s;
      valid_r    <= valid_nxt_s;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_funct   <= id_funct;
    end
  end

  assign ex_jump     = ctrl_r.jump;
  assign ex_Branch   = ctrl_r.branch;
  assign ex_Bne      = ctrl_r.bne;
  assign ex_MemRead  = ctrl_r.mem_read;
  assign ex_MemtoReg = ctrl_r.mem_to_reg;
  assign ex_MemWrite = ctrl_r.mem_write;
  assign ex_ALUSrc   = ctrl_r.alu_src;
  assign ex_RegWrite = ctrl_r.reg_write;
  assign ex_RegDst   = ctrl_r.reg_dst;
  assign ex_ALUOp    = ctrl_r.alu_op;
  assign ex_valid    = valid_r;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating event counters for stalls and flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (stall_s) begin
        stall_cnt_r <= sat_inc16(stall_cnt_r);
      end
      if (flush_i) begin
        flush_cnt_r <= sat_inc16(flush_cnt_r);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; counter checks build only with ID_EX_PERF_CNT_EN.
module tb_id_ex_pipe;
  import core_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic reset;
  logic id_jump, id_Branch, id_Bne, id_MemRead, id_MemtoReg, id_MemWrite;
  logic id_ALUSrc, id_RegWrite, id_RegDst;
  logic [1:0] id_ALUOp;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [5:0] id_funct;
  logic flush_i;
  logic ex_jump, ex_Branch, ex_Bne, ex_MemRead, ex_MemtoReg, ex_MemWrite;
  logic ex_ALUSrc, ex_RegWrite, ex_RegDst;
  logic [1:0] ex_ALUOp;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0] ex_funct;
  logic ex_valid, stall_o, pc_write_o, ifid_write_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .id_jump(id_jump), .id_Branch(id_Branch), .id_Bne(id_Bne),
    .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite),
    .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst),
    .id_ALUOp(id_ALUOp), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .flush_i(flush_i),
    .ex_jump(ex_jump), .ex_Branch(ex_Branch), .ex_Bne(ex_Bne),
    .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst),
    .ex_ALUOp(ex_ALUOp), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .ex_valid(ex_valid), .stall_o(stall_o),
    .pc_write_o(pc_write_o),
`ifdef ID_EX_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .ifid_write_o(ifid_write_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic id_nop();
    {id_jump, id_Branch, id_Bne, id_MemRead, id_MemtoReg, id_MemWrite} = 6'b0;
    {id_ALUSrc, id_RegWrite, id_RegDst} = 3'b0;
    id_ALUOp = 2'b00;
    id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0; id_pc4 = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_funct = 6'd0;
  endtask

  task automatic id_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    id_nop();
    id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_ALUOp = ALUOP_ADD;
    id_rs = rs; id_rt = rt; id_imm = imm;
  endtask

  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    id_nop();
    id_MemRead = 1'b1; id_MemtoReg = 1'b1; id_ALUSrc = 1'b1; id_RegWrite = 1'b1;
    id_ALUOp = ALUOP_ADD; id_rs = rs; id_rt = rt; id_imm = 32'd4;
  endtask

  task automatic id_sw(input logic [4:0] rs, input logic [4:0] rt);
    id_nop();
    id_MemWrite = 1'b1; id_ALUSrc = 1'b1; id_ALUOp = ALUOP_ADD;
    id_rs = rs; id_rt = rt; id_imm = 32'd8;
  endtask

  task automatic id_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_nop();
    id_RegDst = 1'b1; id_RegWrite = 1'b1; id_ALUOp = ALUOP_RTYPE;
    id_rs = rs; id_rt = rt; id_rd = rd; id_funct = 6'h20;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " ctrl"}, {ex_jump, ex_Branch, ex_Bne, ex_MemRead, ex_MemtoReg, ex_MemWrite,
                           ex_ALUSrc, ex_RegWrite, ex_RegDst, ex_ALUOp}, 64'd0);
    check({tag, " valid"}, ex_valid, 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    flush_i = 1'b0;
    id_nop();
    id_jump = 1'b1; id_MemRead = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 2'b11;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    id_rs = 5'd7; id_rt = 5'd7; id_rd = 5'd3; id_funct = 6'h2A;
    step(); step();
    check("rst ctrl", {ex_jump, ex_MemRead, ex_RegWrite, ex_ALUOp}, 64'd0);
    check("rst valid", ex_valid, 64'd0);
    check("rst data", {ex_rs_data, ex_imm}, 64'd0);
    check("rst idx", {ex_rs, ex_rt, ex_rd, ex_funct}, 64'd0);
    check("rst stall", stall_o, 64'd0);

    // Reset release and first addi
    id_addi(5'd1, 5'd2, 32'd5);
    id_pc4 = 32'h0000_0104;
    reset = 1'b1;
    step();
    check("addi regwrite", ex_RegWrite, 64'd1);
    check("addi imm", ex_imm, 64'd5);
    check("addi valid", ex_valid, 64'd1);
    check("addi pc4", ex_pc4, 64'h104);
    check("addi rt", ex_rt, 64'd2);

    // Load-use on rs
    id_lw(5'd1, 5'd8);
    step();
    check("lw memread", ex_MemRead, 64'd1);
    id_add(5'd8, 5'd2, 5'd3);
    #1;
    check("lu stall", stall_o, 64'd1);
    check("lu pcw", pc_write_o, 64'd0);
    check("lu ifidw", ifid_write_o, 64'd0);
    step();
    check_bubble("lu bubble");
    check("lu stall drop", stall_o, 64'd0);
    step();
    check("lu add latched", {ex_RegDst, ex_RegWrite, ex_ALUOp, ex_valid}, 64'b11101);
    check("lu add rd", ex_rd, 64'd3);
    check("lu add funct", ex_funct, 64'h20);

    // rt sensitivity
    id_lw(5'd1, 5'd9);
    step();
    id_addi(5'd1, 5'd9, 32'd1);
    #1;
    check("rt addi nostall", stall_o, 64'd0);
    id_sw(5'd1, 5'd9);
    #1;
    check("rt sw stall", stall_o, 64'd1);
    id_add(5'd4, 5'd9, 5'd5);
    #1;
    check("rt add stall", stall_o, 64'd1);
    step();
    check_bubble("rt bubble");

    // $zero never stalls
    id_lw(5'd1, 5'd0);
    step();
    id_addi(5'd0, 5'd0, 32'd1);
    #1;
    check("zero rs", stall_o, 64'd0);
    id_add(5'd0, 5'd0, 5'd6);
    #1;
    check("zero rs rt", stall_o, 64'd0);
    step();
    check("zero add valid", ex_valid, 64'd1);

    // Flush beats stall
    id_lw(5'd1, 5'd8);
    step();
    id_add(5'd8, 5'd2, 5'd3);
    flush_i = 1'b1;
    #1;
    check("flush nostall", stall_o, 64'd0);
    check("flush pcw", pc_write_o, 64'd1);
    step();
    flush_i = 1'b0;
    check_bubble("flush bubble");

    // Back-to-back loads
    id_lw(5'd1, 5'd8);
    step();
    id_lw(5'd8, 5'd9);
    #1;
    check("b2b stall1", stall_o, 64'd1);
    step();
    check_bubble("b2b bubble1");
    step();
    check("b2b lw2", {ex_MemRead, ex_valid, 3'(ex_rt)}, {2'b11, 3'd1});
    id_add(5'd9, 5'd2, 5'd3);
    #1;
    check("b2b stall2", stall_o, 64'd1);
    step();
    check_bubble("b2b bubble2");

    // Reset mid-stall
    id_lw(5'd1, 5'd8);
    step();
    id_add(5'd8, 5'd2, 5'd3);
    #1;
    check("mid stall", stall_o, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid rst memread", ex_MemRead, 64'd0);
    check("mid rst valid", ex_valid, 64'd0);
    check("mid rst stall", stall_o, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post rst stall", stall_o, 64'd0);
    step();
    check("post rst add", {ex_RegDst, ex_valid}, 64'b11);

`ifdef ID_EX_PERF_CNT_EN
    @(negedge clk);
    reset = 1'b0;
    id_nop();
    #1;
    check("cnt rst", {stall_cnt, flush_cnt}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_lw(5'd1, 5'd8);
      step();
      id_add(5'd8, 5'd2, 5'd3);
      step();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      id_lw(5'd1, 5'd8);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
    end
    check("stall cnt", stall_cnt, 64'd3);
    check("flush cnt", flush_cnt, 64'd2);
    force dut.stall_cnt_r = 16'hFFFE;
    #1;
    release dut.stall_cnt_r;
    for (int i = 0; i < 2; i++) begin
      id_lw(5'd1, 5'd8);
      step();
      id_add(5'd8, 5'd2, 5'd3);
      step();
      step();
    end
    check("stall cnt sat", stall_cnt, 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the instruction decoder's control unit.
- Latches the decoder control bundle plus ID-stage operands into EX.
- Detects load-use hazards: inserts a bubble and freezes PC and IF/ID.
- Zeroes the control bundle on a branch/jump flush.

Parameters:
DATA_W, 32, width of operand, immediate and PC+4 fields
REG_AW, 5, register-index width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
id_jump, id_Branch, id_Bne, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_RegDst  in  1 each  decoder control bits
id_ALUOp  in  2  decoder ALUOp
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4 of ID instruction
id_rs, id_rt, id_rd  in  REG_AW  register indices
id_funct  in  6  funct field
flush_i  in  1  kill ID instruction (taken branch/jump)
ex_* (one per id_* above, same width)  out  -  registered copies
ex_valid  out  1  EX holds a real instruction
stall_o  out  1  load-use stall this cycle
pc_write_o, ifid_write_o  out  1  write enables for PC and IF/ID (= ~stall_o)

Behaviour:
- Reset (reset=0, async): all ex_* outputs and ex_valid go to 0 immediately and stay 0 while reset is low. The first update after release is at the next rising edge.
- Hazard (combinational): uses_rt = ~id_ALUSrc | id_MemWrite.
- hazard = ex_MemRead & ex_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt))).
- stall_o = hazard & ~flush_i. A flush kills the dependent instruction, so there is no stall.
- pc_write_o = ifid_write_o = ~stall_o.
- Per rising edge, priority flush > stall > normal:
  - flush_i=1: all control outputs (jump, Branch, Bne, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, RegDst) = 0, ex_ALUOp = 00, ex_valid = 0. Data fields load from id_* (don't-care).
  - stall_o=1: same bubble as flush (controls 0, ex_valid=0). ID holds, so the instruction re-presents next cycle.
  - normal: every ex_* <= id_*, ex_valid <= 1.
- A bubble has MemtoReg=0, but RegWrite=0 and MemWrite=0 make it architecturally inert.
- Latency: one cycle from ID inputs to ex_* outputs.
- A stall lasts exactly one cycle per load-use pair: the bubble clears ex_MemRead, so hazard drops next cycle.
- Back-to-back loads each stall independently.
- $zero rule: ex_rt=0 never stalls.
- Reset asserted mid-stall: outputs clear immediately. After release, stall_o is 0 until a real load reaches EX.

Optional Feature:
Macro: ID_EX_PERF_CNT_EN
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each increments by 1 on every rising edge where stall_o=1 (resp. flush_i=1).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package core_pkg:
  - OP_RTYPE=6'b000000, OP_ADDI=6'b001000, OP_ANDI=6'b001100, OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_LW=6'b100011, OP_SW=6'b101011, OP_J=6'b000010
  - ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10, ALUOP_AND=2'b11
  - CTRL_W=11 (control bundle width)
- One sub-module: load_use_detect, purely combinational, computing hazard from ex_MemRead, ex_valid, ex_rt, id_rs, id_rt, uses_rt.

Test Plan:
1. Reset: hold reset=0 with random id_* inputs -> all ex_* = 0, ex_valid = 0, stall_o = 0. Release, present addi (RegWrite=1, ALUSrc=1, imm=5) -> next edge: ex_RegWrite=1, ex_imm=5, ex_valid=1.
2. Load-use: lw $t0 (ex_rt=8, MemRead=1) in EX, add with id_rs=8 in ID -> stall_o=1, pc_write_o=0. Next edge: bubble (all control 0, ex_valid=0). Following edge: add latched, stall_o=0.
3. rt sensitivity: lw ex_rt=9 in EX; ID addi with id_rt=9 (ALUSrc=1) -> stall_o=0. ID sw with id_rt=9 -> stall_o=1.
4. $zero: lw with ex_rt=0 in EX, id_rs=0 -> stall_o=0.
5. Flush vs stall: hazard present and flush_i=1 -> stall_o=0, pc_write_o=1. Next edge: bubble with ex_valid=0.
6. With ID_EX_PERF_CNT_EN defined: 3 stalls and 2 flushes -> stall_cnt=3, flush_cnt=2. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
